mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
Multicycle control unit that drives the datapath's 32-bit ALU.
- Sequences MIPS-subset instructions through fetch/decode/execute/memory/writeback states.
- Issues the 4-bit ALU operation code, samples the ALU zero flag for branches, and drives all datapath enables and muxes.
- Sits beside the datapath: register file, PC, IR, memory port and ALU.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles to wait for mem_ready_i before a bus error; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- opcode_i  in  6  IR[31:26]; stable from DECODE onward.
- funct_i  in  6  IR[5:0].
- zf_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- pc_we_o  out  1  PC write enable.
- pc_src_o  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- iord_o  out  1  memory address source: 0 PC, 1 ALUOut.
- mem_rd_o  out  1  memory read request.
- mem_wr_o  out  1  memory write request.
- ir_we_o  out  1  IR load.
- reg_dst_o  out  1  register write address: 0 rt, 1 rd.
- mem_to_reg_o  out  1  register write data: 0 ALUOut, 1 MDR.
- reg_we_o  out  1  register file write enable.
- alu_src_a_o  out  1  ALU A input: 0 PC, 1 register A.
- alu_src_b_o  out  2  ALU B input: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 shifted sign-extended immediate.
- alu_op_o  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- illegal_o  out  1  one-cycle pulse on an unsupported opcode or funct.
- bus_err_o  out  1  one-cycle pulse on a memory-wait timeout.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset (rst_ni low, asynchronous): state goes to IDLE; wait counter cleared; every output is 0, including state_o=0.
- Outputs are a Moore decode of the state register.
  - Exception: pc_we_o in BRANCH = zf_i, combinationally.
  - illegal_o and bus_err_o are registered pulses.
- Wait counter:
  - Cleared on entering any memory state.
  - Increments each cycle the state waits with mem_ready_i=0.
  - Reaching MEM_WAIT_MAX causes bus_err_o for 1 cycle and a return to FETCH without any PC, IR or register write.
- Decoding is driven by funct_i and opcode_i as listed under each state.

States (encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12):
- IDLE: all outputs 0. Next state FETCH, unconditionally.
- FETCH: mem_rd_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=ADD.
  - When mem_ready_i=1: ir_we_o=1, pc_we_o=1, pc_src_o=00, next state DECODE.
  - Otherwise stay in FETCH; ir_we_o=0, pc_we_o=0.
- DECODE: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=ADD (branch target precompute). Next state by opcode:
  - 100011 (lw) or 101011 (sw): MEMADR.
  - 000000 (R-type): EXEC, provided funct is legal.
  - 000100 (beq): BRANCH.
  - 000010 (j): JUMP.
  - 001000 (addi): ADDIEX.
  - Any other opcode, or R-type with an illegal funct: illegal_o pulse, next state FETCH.
- MEMADR: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=ADD. Next state MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_rd_o=1, iord_o=1. Waits for mem_ready_i, then MEMWB.
- MEMWB: reg_we_o=1, reg_dst_o=0, mem_to_reg_o=1. Next state FETCH.
- MEMWR: mem_wr_o=1, iord_o=1. Waits for mem_ready_i, then FETCH.
- EXEC: alu_src_a_o=1, alu_src_b_o=00, alu_op_o from funct:
  - 100000 → 0010; 100010 → 0110; 100100 → 0000; 100101 → 0001; 101010 → 0111; 100111 → 1100.
  - Next state ALUWB.
- ALUWB: reg_we_o=1, reg_dst_o=1, mem_to_reg_o=0. Next state FETCH.
- BRANCH: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=SUB, pc_src_o=01, pc_we_o=zf_i. Next state FETCH.
- JUMP: pc_we_o=1, pc_src_o=10. Next state FETCH.
- ADDIEX: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=ADD. Next state ADDIWB.
- ADDIWB: reg_we_o=1, reg_dst_o=0, mem_to_reg_o=0. Next state FETCH.

Latency (mem_ready_i held at 1), counted from FETCH entry back to FETCH:
- R-type 4, addi 4, lw 5, sw 4, beq 3, j 3 cycles.

Corner cases:
- Reset asserted mid-instruction: the next cycle shows IDLE outputs (all 0); no partial write completes after reset.
- mem_ready_i in non-memory states is ignored.
- mem_ready_i=1 on the same cycle the counter hits MEM_WAIT_MAX: completion wins, no bus error.

Decomposition:
- Package mc_pkg:
  - opcode constants, funct constants, ALU op constants.
  - state enum with the fixed encodings above.
  - pc_src and alu_src_b encodings.
- Sub-module alu_op_decoder: combinational funct → {alu_op[3:0], legal}, shared with DECODE for the illegal-funct check.

Test Plan:
- Reset release with mem_ready_i=1, R-type add (opcode 000000, funct 100000) → states IDLE, FETCH, DECODE, EXEC, ALUWB, FETCH; alu_op_o=0010 in EXEC; reg_we_o=1 and reg_dst_o=1 in ALUWB only.
- lw (100011) with mem_ready_i low for 3 cycles in MEMRD → MEMRD held 4 cycles; MEMWB has reg_we_o=1 and mem_to_reg_o=1; total 8 cycles.
- beq (000100): run once with zf_i=1 → pc_we_o=1 and pc_src_o=01 in BRANCH; run with zf_i=0 → pc_we_o=0.
- Opcode 111111, then R-type funct 000000 → illegal_o pulses exactly 1 cycle each; return to FETCH; no reg_we_o or mem_wr_o asserted.
- MEM_WAIT_MAX=15, sw with mem_ready_i stuck at 0 → bus_err_o pulses after 15 wait cycles, then FETCH; mem_wr_o drops afterwards.
- Reset asserted in MEMWR and in ALUWB → all outputs 0 immediately (asynchronous); after release, IDLE then FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, functs, ALU ops, states, mux selects.
package mc_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FN_W     = 6;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FN_W-1:0] FN_NOR = 6'b100111;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// R-type funct to ALU operation map; also flags which functs are supported.
module alu_op_decoder
    import mc_pkg::*;
(
    input  logic [FN_W-1:0]     funct,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                legal
);

    // Funct lookup; unsupported functs fall back to ADD and clear legal
    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_NOR:  alu_op = ALU_NOR;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-subset control FSM: Moore decode of the state register plus
// registered illegal/bus-error pulses and a memory-wait timeout counter.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [OP_W-1:0]     opcode_i,
    input  logic [FN_W-1:0]     funct_i,
    input  logic                zf_i,
    input  logic                mem_ready_i,
    output logic                pc_we_o,
    output logic [1:0]          pc_src_o,
    output logic                iord_o,
    output logic                mem_rd_o,
    output logic                mem_wr_o,
    output logic                ir_we_o,
    output logic                reg_dst_o,
    output logic                mem_to_reg_o,
    output logic                reg_we_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                illegal_o,
    output logic                bus_err_o,
    output logic [STATE_W-1:0]  state_o
);

    localparam int unsigned CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_e                state, state_d;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_d;
    logic                  illegal_q, illegal_d;
    logic                  bus_err_q;
    logic                  mem_wait, timeout;
    logic [ALU_OP_W-1:0]   fn_alu_op;
    logic                  fn_legal;

    alu_op_decoder u_alu_op_decoder (
        .funct  (funct_i),
        .alu_op (fn_alu_op),
        .legal  (fn_legal)
    );

    // Wait tracking: counter runs only while a memory state stalls, zero otherwise
    always_comb begin
        mem_wait   = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !mem_ready_i;
        timeout    = (MEM_WAIT_MAX != 0) && mem_wait
                     && ((32'(wait_cnt) + 32'd1) == 32'(MEM_WAIT_MAX));
        wait_cnt_d = (mem_wait && !timeout) ? wait_cnt + CNT_W'(1) : '0;
    end

    // State, counter and pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= timeout;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d      = state;
        illegal_d    = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = PC_SRC_ALU;
        iord_o       = 1'b0;
        mem_rd_o     = 1'b0;
        mem_wr_o     = 1'b0;
        ir_we_o      = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_we_o     = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_REG;
        alu_op_o     = ALU_AND;
        case (state)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_rd_o    = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                alu_op_o    = ALU_ADD;
                pc_src_o    = PC_SRC_ALU;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b_o = SRCB_IMM_SH;
                alu_op_o    = ALU_ADD;
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_RTYPE: begin
                        if (fn_legal) begin
                            state_d = S_EXEC;
                        end else begin
                            illegal_d = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALU_ADD;
                state_d     = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_rd_o = 1'b1;
                iord_o   = 1'b1;
                if (mem_ready_i)  state_d = S_MEMWB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEMWB: begin
                reg_we_o     = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_wr_o = 1'b1;
                iord_o   = 1'b1;
                if (mem_ready_i || timeout) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_REG;
                alu_op_o    = fn_alu_op;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we_o  = 1'b1;
                reg_dst_o = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_REG;
                alu_op_o    = ALU_SUB;
                pc_src_o    = PC_SRC_ALUOUT;
                pc_we_o     = zf_i;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_we_o  = 1'b1;
                pc_src_o = PC_SRC_JUMP;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALU_ADD;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_we_o = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign illegal_o = illegal_q;
    assign bus_err_o = bus_err_q;
    assign state_o   = state;

endmodule

// File: tb/tb_mc_control.sv
// Randomized scoreboard bench for mc_control: an instruction-level model emits one
// expected output vector per cycle; a negedge monitor pops and compares.
module tb_mc_control;

    localparam int WMAX = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [5:0] opcode_i = '0;
    logic [5:0] funct_i = '0;
    logic       zf_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       pc_we_o, iord_o, mem_rd_o, mem_wr_o, ir_we_o, reg_dst_o;
    logic       mem_to_reg_o, reg_we_o, alu_src_a_o, illegal_o, bus_err_o;
    logic [1:0] pc_src_o, alu_src_b_o;
    logic [3:0] alu_op_o, state_o;

    always #5 clk = ~clk;

    mc_control #(.MEM_WAIT_MAX(WMAX)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct_i(funct_i),
        .zf_i(zf_i), .mem_ready_i(mem_ready_i), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
        .iord_o(iord_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .ir_we_o(ir_we_o),
        .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_we_o(reg_we_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .illegal_o(illegal_o), .bus_err_o(bus_err_o), .state_o(state_o)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we, alu_a;
        logic [1:0] alu_b;
        logic [3:0] alu_op;
        logic       illegal, bus_err;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   pend_ill = 0;
    bit   pend_be = 0;
    int   kill_state = -1;
    bit   killed = 0;

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic bit fn_ok(logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    endfunction

    function automatic bit op_ok(logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    endfunction

    function automatic logic [3:0] ref_alu(logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b1100;
        endcase
    endfunction

    // Expected control vector of one state, straight from the state table
    function automatic obs_t expect_state(int st, bit rdy, bit zf, logic [5:0] fn);
        obs_t o;
        o = '0;
        o.st = 4'(st);
        case (st)
            1:  begin o.mem_rd = 1; o.alu_b = 2'b01; o.alu_op = 4'b0010;
                      o.ir_we = rdy; o.pc_we = rdy; end
            2:  begin o.alu_b = 2'b11; o.alu_op = 4'b0010; end
            3:  begin o.alu_a = 1; o.alu_b = 2'b10; o.alu_op = 4'b0010; end
            4:  begin o.mem_rd = 1; o.iord = 1; end
            5:  begin o.reg_we = 1; o.mem_to_reg = 1; end
            6:  begin o.mem_wr = 1; o.iord = 1; end
            7:  begin o.alu_a = 1; o.alu_op = ref_alu(fn); end
            8:  begin o.reg_we = 1; o.reg_dst = 1; end
            9:  begin o.alu_a = 1; o.alu_op = 4'b0110; o.pc_src = 2'b01; o.pc_we = zf; end
            10: begin o.pc_we = 1; o.pc_src = 2'b10; end
            11: begin o.alu_a = 1; o.alu_b = 2'b10; o.alu_op = 4'b0010; end
            12: begin o.reg_we = 1; end
            default: ;
        endcase
        return o;
    endfunction

    // One clock of stimulus; pushes the cycle's expected outputs
    task automatic step(int st, bit rdy, bit zf, logic [5:0] op, logic [5:0] fn);
        obs_t e;
        if (killed) return;
        @(posedge clk); #1;
        mem_ready_i = rdy; zf_i = zf; opcode_i = op; funct_i = fn;
        if (st == kill_state) begin
            rst_ni = 1'b0;
            killed = 1; kill_state = -1;
            pend_ill = 0; pend_be = 0;
            e = '0;
        end else begin
            e = expect_state(st, rdy, zf, fn);
            e.illegal = pend_ill; e.bus_err = pend_be;
            pend_ill = 0; pend_be = 0;
        end
        exp_q.push_back(e);
    endtask

    // One reset cycle followed by the IDLE cycle after release
    task automatic do_reset();
        obs_t z;
        z = '0;
        @(posedge clk); #1;
        rst_ni = 1'b0; mem_ready_i = rb(); zf_i = rb(); opcode_i = r6(); funct_i = r6();
        exp_q.push_back(z);
        @(posedge clk); #1;
        rst_ni = 1'b1; mem_ready_i = rb(); zf_i = rb();
        exp_q.push_back(z);
        killed = 0; pend_ill = 0; pend_be = 0;
    endtask

    // Memory access that stalls 'waits' cycles; at WMAX or more the access times out
    task automatic mem_phase(int st, int waits, logic [5:0] op, logic [5:0] fn, output bit timed);
        bit f;
        f = (st == 1);
        timed = 0;
        if (waits >= WMAX) begin
            for (int i = 0; i < WMAX; i++) step(st, 0, rb(), f ? r6() : op, f ? r6() : fn);
            if (!killed) pend_be = 1;
            timed = 1;
        end else begin
            for (int i = 0; i < waits; i++) step(st, 0, rb(), f ? r6() : op, f ? r6() : fn);
            step(st, 1, rb(), f ? r6() : op, f ? r6() : fn);
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return WMAX - 1;
        if (r == 1) return WMAX + int'($urandom_range(0, 2));
        return int'($urandom_range(0, 3));
    endfunction

    // Instruction-level model: fetch, decode, then the opcode's remaining phases
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit zf, int fw, int mw);
        bit t;
        mem_phase(1, fw, op, fn, t);
        if (t) mem_phase(1, 0, op, fn, t);
        step(2, rb(), rb(), op, fn);
        if (!op_ok(op) || (op == OP_R && !fn_ok(fn))) begin
            if (!killed) pend_ill = 1;
        end else begin
            case (op)
                OP_LW:   begin step(3, rb(), rb(), op, fn); mem_phase(4, mw, op, fn, t);
                               if (!t) step(5, rb(), rb(), op, fn); end
                OP_SW:   begin step(3, rb(), rb(), op, fn); mem_phase(6, mw, op, fn, t); end
                OP_R:    begin step(7, rb(), rb(), op, fn); step(8, rb(), rb(), op, fn); end
                OP_BEQ:  step(9, rb(), zf, op, fn);
                OP_J:    step(10, rb(), rb(), op, fn);
                default: begin step(11, rb(), rb(), op, fn); step(12, rb(), rb(), op, fn); end
            endcase
        end
        if (killed) do_reset();
        kill_state = -1;
    endtask

    // Monitor: compare DUT outputs against the next expected vector, mid-cycle
    always @(negedge clk) begin
        obs_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state_o, pc_we_o, pc_src_o, iord_o, mem_rd_o, mem_wr_o, ir_we_o, reg_dst_o,
                 mem_to_reg_o, reg_we_o, alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o, bus_err_o};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL ctrl_vec t=%0t exp_state=%0d actual=%b required=%b", $time, e.st, a, e);
            end
        end
    end

    initial begin
        logic [5:0] fn, op;
        int r;
        do_reset();
        run_instr(OP_R, 6'b100000, 0, 0, 0);
        run_instr(OP_LW, 6'b000000, 0, 0, 3);
        run_instr(OP_BEQ, 6'b000000, 1, 0, 0);
        run_instr(OP_BEQ, 6'b000000, 0, 0, 0);
        run_instr(6'b111111, 6'b100000, 0, 0, 0);
        run_instr(OP_R, 6'b000000, 0, 0, 0);
        run_instr(OP_SW, 6'b000000, 0, 0, WMAX);
        run_instr(OP_LW, 6'b000000, 0, 0, WMAX - 1);
        run_instr(OP_J, 6'b000000, 0, WMAX, 0);
        kill_state = 6;
        run_instr(OP_SW, 6'b000000, 0, 0, 2);
        kill_state = 8;
        run_instr(OP_R, 6'b100010, 0, 0, 0);
        run_instr(OP_ADDI, 6'b000000, 0, 1, 0);

        for (int n = 0; n < 300; n++) begin
            r  = int'($urandom_range(0, 7));
            fn = r6();
            case (r)
                0: op = OP_LW;
                1: op = OP_SW;
                2: begin
                    op = OP_R;
                    case ($urandom_range(0, 5))
                        0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
                        3: fn = 6'b100101; 4: fn = 6'b101010; default: fn = 6'b100111;
                    endcase
                end
                3: op = OP_BEQ;
                4: op = OP_J;
                5: op = OP_ADDI;
                6: begin op = r6(); while (op_ok(op)) op = r6(); end
                default: op = OP_R;
            endcase
            if ($urandom_range(0, 24) == 0) kill_state = int'($urandom_range(1, 12));
            run_instr(op, fn, rb(), pick_wait(), pick_wait());
        end
        run_instr(OP_J, 6'b000000, 0, 0, 0);

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
